uart_parity_unit: RTL and testbench
===================================

Name: uart_parity_unit

Overview:
Parametrised, registered parity unit for the UART datapath.
- Parallel path: computes the parity bit of a captured word for the Tx frame builder.
- Serial path: accumulates parity bit-by-bit as a serializer/deserializer shifts data, then checks a received parity bit.
- Over the current combinational calculator it adds: configurable data length, mark/space modes, a parity disable, a valid pulse, and Rx error detection.
- Sits between the frame FSM and the Tx/Rx shift registers.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (legal 5..16)
LEN_W, $clog2(DATA_WIDTH+1), width of the length field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
par_en  in  1  1 = parity enabled; 0 = parity suppressed
par_typ  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
data_len  in  LEN_W  number of LSB-justified data bits in the frame
data_valid  in  1  parallel capture strobe
p_data  in  DATA_WIDTH  parallel data word
par_bit  out  1  registered parallel parity result
par_valid  out  1  one-cycle pulse, par_bit updated
ser_clr  in  1  start new serial frame: clear accumulator, latch config
ser_en  in  1  accumulate ser_bit this cycle
ser_bit  in  1  serial data bit
ser_par  out  1  running serial parity (final value when ser_done=1)
ser_done  out  1  high once data_len bits accumulated; held until ser_clr
chk_en  in  1  compare rx_par against ser_par
rx_par  in  1  received parity bit
par_err  out  1  sticky parity error, cleared by ser_clr or reset

Behaviour:
- Reset (rst=0, async): par_bit=0, par_valid=0, ser_par=0, ser_done=0, par_err=0; serial FSM goes to IDLE; bit counter=0; latched config = even, len=DATA_WIDTH, enabled.
- Effective length: len_eff = min(data_len, DATA_WIDTH). p_data bits at index >= len_eff are masked to 0.
- Parity function P(x):
  - even: XOR of the bits.
  - odd: inverted XOR.
  - mark: 1.
  - space: 0.
  - par_en=0: 0.
  - len_eff=0: even gives 0, odd gives 1.
- Parallel path:
  - Cycle N with data_valid=1: sample p_data, par_typ, par_en, data_len.
  - Cycle N+1: par_bit = P(masked p_data); par_valid=1 for exactly one cycle.
  - Latency: 1 clock.
  - Back-to-back data_valid: each yields its own pulse at N+1; throughput 1 word per cycle.
  - par_bit holds its value between strobes.
- Serial FSM states: IDLE, ACCUM, DONE.
  - Any state, ser_clr=1: latch par_typ/par_en/data_len, count=0, acc=0, ser_done=0, par_err=0.
    - Next state is ACCUM, or DONE if len_eff=0.
    - ser_clr has priority: a ser_en in the same cycle is discarded.
  - ACCUM, ser_en=1: acc ^= ser_bit; count++. When count reaches len_eff, go to DONE and set ser_done=1 on the next edge.
  - IDLE or DONE, ser_en=1: ignored. Counter saturates; the extra bit is not accumulated.
- ser_par = P over acc, using the latched config. It is registered and valid every cycle; it is final once ser_done=1.
- Config pins changing mid-frame have no effect until the next ser_clr or data_valid.
- Check:
  - chk_en=1 while ser_done=1 and latched par_en=1: if rx_par != ser_par, par_err=1 on the next edge.
  - chk_en is ignored before DONE or when latched par_en=0.
  - par_err is sticky.
- Parallel and serial paths are independent and may be active in the same cycle.
- rst asserted mid-frame: immediate return to the reset values above; a partial accumulation is lost.

Decomposition:
- Shared package uart_pkg: parity type encodings (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11) and the serial FSM state encoding.
- One natural sub-module, uart_parity_fn: combinational masked reduce plus mode select. It is instantiated twice, once for the parallel path and once for the serial final value.

Test Plan:
- Reset then data_valid, p_data=8'hA5, len=8, even -> N+1: par_bit=0, par_valid=1 for 1 cycle. Repeat with odd -> par_bit=1.
- p_data=8'hFF, data_len=7, even -> par_bit=1 (bit 7 masked). data_len=0, odd -> par_bit=1. data_len=12 with DATA_WIDTH=8 -> clamped to 8.
- Modes on p_data=8'h00: mark -> 1; space -> 0; par_en=0, odd -> 0.
- Serial: ser_clr, len=5, even; shift bits 1,0,1,1,0 -> ser_done after 5th bit, ser_par=1. chk_en with rx_par=1 -> par_err=0; new frame with rx_par=0 -> par_err=1 and stays 1 until ser_clr.
- Serial edge cases: ser_clr and ser_en in the same cycle -> bit discarded, count=0; ser_en after DONE -> ser_par unchanged; chk_en before DONE -> no error.
- Reset mid-frame after 3 of 8 bits -> all outputs 0 immediately; the following frame computes correctly from a clean state.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, serial parity FSM states,
// and the mode-select helper used by the parity calculators.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_t;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'b00,
        SER_ACCUM = 2'b01,
        SER_DONE  = 2'b10
    } ser_state_t;

    // Turns a raw XOR reduction into the parity bit for the selected mode.
    function automatic logic par_select(input logic en, input par_typ_t typ, input logic x);
        logic r;
        r = 1'b0;
        if (en) begin
            case (typ)
                PAR_EVEN:  r = x;
                PAR_ODD:   r = ~x;
                PAR_MARK:  r = 1'b1;
                default:   r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_parity_fn.sv
// Combinational parity calculator: clamps the length to DATA_WIDTH, masks
// bits above the effective length, reduces and applies the parity mode.
module uart_parity_fn
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [LEN_W-1:0]      len,
    input  logic [1:0]            typ,
    input  logic                  en,
    output logic                  par
);

    logic [LEN_W-1:0] len_eff;
    logic             red;

    // Masked XOR reduction over the LSB-justified data bits, then mode select.
    always_comb begin
        len_eff = (len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : len;
        red     = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (LEN_W'(i) < len_eff) begin
                red = red ^ data[i];
            end
        end
        par = par_select(en, par_typ_t'(typ), red);
    end

endmodule

// File: rtl/uart_parity_unit.sv
// Registered UART parity unit: a one-cycle parallel parity path for the Tx
// frame builder and a serial accumulate/check path for shifted data.
module uart_parity_unit
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  par_en,
    input  logic [1:0]            par_typ,
    input  logic [LEN_W-1:0]      data_len,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  par_bit,
    output logic                  par_valid,
    input  logic                  ser_clr,
    input  logic                  ser_en,
    input  logic                  ser_bit,
    output logic                  ser_par,
    output logic                  ser_done,
    input  logic                  chk_en,
    input  logic                  rx_par,
    output logic                  par_err
);

    // ---------------- parallel path ----------------
    logic par_d;

    uart_parity_fn #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_W      (LEN_W)
    ) u_par_fn (
        .data (p_data),
        .len  (data_len),
        .typ  (par_typ),
        .en   (par_en),
        .par  (par_d)
    );

    // Capture the parity of the strobed word; pulse valid for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit   <= 1'b0;
            par_valid <= 1'b0;
        end else begin
            par_valid <= data_valid;
            if (data_valid) begin
                par_bit <= par_d;
            end
        end
    end

    // ---------------- serial path ----------------
    ser_state_t       state, state_d;
    logic [LEN_W-1:0] cnt, cnt_d;
    logic             acc, acc_d;
    par_typ_t         cfg_typ, cfg_typ_d;
    logic             cfg_en, cfg_en_d;
    logic [LEN_W-1:0] cfg_len, cfg_len_d;
    logic             err_d;
    logic             ser_par_d;
    logic [LEN_W-1:0] clr_len;

    assign clr_len  = (data_len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : data_len;
    assign ser_done = (state == SER_DONE);

    // ser_par is computed from the next-state accumulator and config so the
    // register always agrees with acc/config after the same edge.
    uart_parity_fn #(
        .DATA_WIDTH (1)
    ) u_ser_fn (
        .data (acc_d),
        .len  (1'b1),
        .typ  (cfg_typ_d),
        .en   (cfg_en_d),
        .par  (ser_par_d)
    );

    // Serial FSM next state: frame start, bit accumulation and parity check.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        acc_d     = acc;
        cfg_typ_d = cfg_typ;
        cfg_en_d  = cfg_en;
        cfg_len_d = cfg_len;
        err_d     = par_err;
        if (ser_clr) begin
            cfg_typ_d = par_typ_t'(par_typ);
            cfg_en_d  = par_en;
            cfg_len_d = clr_len;
            cnt_d     = '0;
            acc_d     = 1'b0;
            err_d     = 1'b0;
            state_d   = (clr_len == '0) ? SER_DONE : SER_ACCUM;
        end else begin
            case (state)
                SER_ACCUM: begin
                    if (ser_en) begin
                        acc_d = acc ^ ser_bit;
                        cnt_d = cnt + LEN_W'(1);
                        if (cnt_d == cfg_len) begin
                            state_d = SER_DONE;
                        end
                    end
                end
                SER_DONE: begin
                    if (chk_en && cfg_en && (rx_par != ser_par)) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Serial state, accumulator, latched config and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SER_IDLE;
            cnt     <= '0;
            acc     <= 1'b0;
            cfg_typ <= PAR_EVEN;
            cfg_en  <= 1'b1;
            cfg_len <= LEN_W'(DATA_WIDTH);
            ser_par <= 1'b0;
            par_err <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            acc     <= acc_d;
            cfg_typ <= cfg_typ_d;
            cfg_en  <= cfg_en_d;
            cfg_len <= cfg_len_d;
            ser_par <= ser_par_d;
            par_err <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_parity_unit.sv
// Directed self-checking bench for uart_parity_unit (DATA_WIDTH = 8).
module tb_uart_parity_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       par_en = 1'b1;
    logic [1:0] par_typ = 2'b00;
    logic [3:0] data_len = 4'd8;
    logic       data_valid = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       par_bit, par_valid;
    logic       ser_clr = 1'b0;
    logic       ser_en = 1'b0;
    logic       ser_bit = 1'b0;
    logic       ser_par, ser_done;
    logic       chk_en = 1'b0;
    logic       rx_par = 1'b0;
    logic       par_err;

    int tests  = 0;
    int failed = 0;

    uart_parity_unit #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .data_len   (data_len),
        .data_valid (data_valid),
        .p_data     (p_data),
        .par_bit    (par_bit),
        .par_valid  (par_valid),
        .ser_clr    (ser_clr),
        .ser_en     (ser_en),
        .ser_bit    (ser_bit),
        .ser_par    (ser_par),
        .ser_done   (ser_done),
        .chk_en     (chk_en),
        .rx_par     (rx_par),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one parallel strobe and check the registered result next cycle.
    task automatic pvec(input string tag, input logic [7:0] d, input logic [3:0] len,
                        input logic [1:0] typ, input logic en, input logic exp);
        data_valid = 1'b1;
        p_data     = d;
        data_len   = len;
        par_typ    = typ;
        par_en     = en;
        tick();
        check({tag, "_bit"}, par_bit, exp);
        check({tag, "_valid"}, par_valid, 1'b1);
    endtask

    task automatic shift(input logic b);
        ser_en  = 1'b1;
        ser_bit = b;
        tick();
        ser_en  = 1'b0;
    endtask

    task automatic start_frame(input logic [3:0] len, input logic [1:0] typ, input logic en);
        ser_clr  = 1'b1;
        data_len = len;
        par_typ  = typ;
        par_en   = en;
        tick();
        ser_clr  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_par_bit", par_bit, 1'b0);
        check("rst_par_valid", par_valid, 1'b0);
        check("rst_ser_par", ser_par, 1'b0);
        check("rst_ser_done", ser_done, 1'b0);
        check("rst_par_err", par_err, 1'b0);
        rst = 1'b1;
        tick();

        // Parallel path, back-to-back strobes
        pvec("a5_even", 8'hA5, 4'd8, 2'b00, 1'b1, 1'b0);
        pvec("a5_odd", 8'hA5, 4'd8, 2'b01, 1'b1, 1'b1);
        pvec("space", 8'h00, 4'd8, 2'b11, 1'b1, 1'b0);
        pvec("ff_len7", 8'hFF, 4'd7, 2'b00, 1'b1, 1'b1);
        pvec("dis_odd", 8'h00, 4'd8, 2'b01, 1'b0, 1'b0);
        pvec("len0_odd", 8'hFF, 4'd0, 2'b01, 1'b1, 1'b1);
        pvec("len12_03", 8'h03, 4'd12, 2'b00, 1'b1, 1'b0);
        pvec("len12_80", 8'h80, 4'd12, 2'b00, 1'b1, 1'b1);
        pvec("len0_even", 8'hFF, 4'd0, 2'b00, 1'b1, 1'b0);
        pvec("mark", 8'h00, 4'd8, 2'b10, 1'b1, 1'b1);
        data_valid = 1'b0;
        p_data     = 8'hFF;
        par_typ    = 2'b00;
        tick();
        check("idle_valid", par_valid, 1'b0);
        check("hold_bit", par_bit, 1'b1);

        // ser_en in IDLE is ignored
        shift(1'b1);
        check("idle_ser_par", ser_par, 1'b0);
        check("idle_ser_done", ser_done, 1'b0);

        // Frame 1: len 5 even, bits 1,0,1,1,0; config pins change mid-frame
        start_frame(4'd5, 2'b00, 1'b1);
        par_typ  = 2'b01;
        data_len = 4'd8;
        check("f1_clr_par", ser_par, 1'b0);
        check("f1_clr_done", ser_done, 1'b0);
        shift(1'b1); shift(1'b0); shift(1'b1); shift(1'b1);
        check("f1_4_done", ser_done, 1'b0);
        check("f1_4_par", ser_par, 1'b1);
        shift(1'b0);
        check("f1_done", ser_done, 1'b1);
        check("f1_par", ser_par, 1'b1);
        chk_en = 1'b1; rx_par = 1'b1;
        tick();
        chk_en = 1'b0;
        check("f1_chk_ok", par_err, 1'b0);
        shift(1'b1);
        check("f1_extra_par", ser_par, 1'b1);
        check("f1_extra_done", ser_done, 1'b1);

        // Frame 2: same data, wrong received parity -> sticky error
        start_frame(4'd5, 2'b00, 1'b1);
        shift(1'b1); shift(1'b0); shift(1'b1); shift(1'b1); shift(1'b0);
        chk_en = 1'b1; rx_par = 1'b0;
        tick();
        chk_en = 1'b0;
        check("f2_err", par_err, 1'b1);
        tick(); tick();
        check("f2_err_sticky", par_err, 1'b1);

        // Frame 3: ser_clr with ser_en same cycle; chk_en before DONE
        ser_en = 1'b1; ser_bit = 1'b1;
        start_frame(4'd5, 2'b00, 1'b1);
        ser_en = 1'b0;
        check("f3_err_clr", par_err, 1'b0);
        check("f3_clr_par", ser_par, 1'b0);
        check("f3_clr_done", ser_done, 1'b0);
        chk_en = 1'b1; rx_par = 1'b1;
        shift(1'b1); shift(1'b1); shift(1'b1); shift(1'b1);
        check("f3_4_done", ser_done, 1'b0);
        check("f3_4_par", ser_par, 1'b0);
        check("f3_early_chk", par_err, 1'b0);
        chk_en = 1'b0;
        shift(1'b1);
        check("f3_done", ser_done, 1'b1);
        check("f3_par", ser_par, 1'b1);

        // Frame 4: odd, len 3, bits 1,0,0
        start_frame(4'd3, 2'b01, 1'b1);
        check("f4_clr_par", ser_par, 1'b1);
        check("f4_clr_done", ser_done, 1'b0);
        shift(1'b1); shift(1'b0); shift(1'b0);
        check("f4_done", ser_done, 1'b1);
        check("f4_par", ser_par, 1'b0);

        // Frame 5: len 0 odd -> immediately done
        start_frame(4'd0, 2'b01, 1'b1);
        check("f5_done", ser_done, 1'b1);
        check("f5_par", ser_par, 1'b1);

        // Frame 6: parity disabled, check ignored
        start_frame(4'd3, 2'b00, 1'b0);
        shift(1'b1); shift(1'b0); shift(1'b0);
        check("f6_done", ser_done, 1'b1);
        check("f6_par", ser_par, 1'b0);
        chk_en = 1'b1; rx_par = 1'b1;
        tick();
        chk_en = 1'b0;
        check("f6_chk_ignored", par_err, 1'b0);

        // Reset mid-frame (with parallel path active too)
        data_valid = 1'b1; p_data = 8'h00;
        start_frame(4'd8, 2'b10, 1'b1);
        data_valid = 1'b0;
        par_typ = 2'b00;
        start_frame(4'd8, 2'b00, 1'b1);
        check("pre_rst_bit", par_bit, 1'b1);
        shift(1'b1); shift(1'b0); shift(1'b0);
        check("pre_rst_par", ser_par, 1'b1);
        check("pre_rst_done", ser_done, 1'b0);
        rst = 1'b0;
        #2;
        check("mid_rst_par_bit", par_bit, 1'b0);
        check("mid_rst_par_valid", par_valid, 1'b0);
        check("mid_rst_ser_par", ser_par, 1'b0);
        check("mid_rst_ser_done", ser_done, 1'b0);
        check("mid_rst_par_err", par_err, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Clean frame after reset: 7 ones in 8 bits, even -> 1
        start_frame(4'd8, 2'b00, 1'b1);
        shift(1'b1); shift(1'b1); shift(1'b1); shift(1'b0);
        shift(1'b1); shift(1'b1); shift(1'b1);
        check("post_7_done", ser_done, 1'b0);
        check("post_7_par", ser_par, 1'b0);
        shift(1'b1);
        check("post_done", ser_done, 1'b1);
        check("post_par", ser_par, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
